muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are 8 to 64.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-006 SHALL have port m_funct3, input, 3 bits: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a, input, XLEN bits: rs1 value (multiplicand/dividend).
REQ-008 SHALL have port operand_b, input, XLEN bits: rs2 value (multiplier/divisor).
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-011 SHALL have port result, output, XLEN bits: registered result.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL latch m_funct3 and both operands, then go to PREP.
REQ-014 While busy=1, start SHALL be ignored; latched inputs SHALL NOT change.
REQ-015 PREP SHALL take absolute values of signed operands, per funct3, and record the result sign; it then goes to CALC with an iteration counter of XLEN.
REQ-016 CALC SHALL run one radix-2 step per cycle for exactly XLEN cycles.
- Multiply: shift-add into a 2*XLEN-bit product.
- Divide: restoring shift-subtract producing quotient and remainder.
- Then go to FIX.
REQ-017 FIX SHALL apply sign correction and select the output.
- MUL: low XLEN bits; MULH/MULHSU/MULHU: high XLEN bits.
- DIV/DIVU: quotient; REM/REMU: remainder.
- Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Then go to DONE.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, load result, then return to IDLE.
REQ-019 Normal latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+XLEN+2, i.e. XLEN+3 cycles (35 for XLEN=32).
REQ-020 result SHALL hold its value after done until the next DONE; result SHALL change at no other time.
REQ-021 Divisor zero SHALL give quotient all-ones and remainder = operand_a, for signed and unsigned forms.
REQ-022 Signed overflow (a = most-negative value, b = -1, DIV/REM) SHALL give quotient = operand_a and remainder 0.
REQ-023 flush=1 in any busy state SHALL return the FSM to IDLE at the next edge, with no done pulse and result unchanged.
REQ-024 flush=1 in IDLE SHALL have no effect and SHALL block acceptance of a simultaneous start.
REQ-025 start=1 in the DONE cycle SHALL be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-026 reset_n=0 SHALL immediately, regardless of clock, force state IDLE, busy=0, done=0, result=0, and clear the counter and datapath registers.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; after release, no done pulse occurs until a new start is accepted.

Configuration
REQ-028 Macro MULDIV_EARLY_OUT_EN SHALL select the behaviour for the special divide cases.
- Defined: divisor-zero and signed-overflow cases SHALL skip CALC and FIX, going PREP to DONE, so done occurs 2 cycles after the start edge.
- Undefined: every operation SHALL take the fixed XLEN+3 latency.
- Result values per REQ-021/022 SHALL be identical in both builds.

Verification (XLEN=32)
REQ-029 The bench SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 35 cycles after start, busy high 35 cycles.
REQ-030 The bench SHALL cover the high-word multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 The bench SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
REQ-032 The bench SHALL cover divide-by-zero and overflow:
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- done at cycle 2 with MULDIV_EARLY_OUT_EN, cycle 35 without.
REQ-033 The bench SHALL cover flush asserted on the 10th CALC cycle -> busy=0 next cycle, no done, result unchanged; the following MUL 3x4 -> 12.
REQ-034 The bench SHALL cover reset_n pulsed low mid-CALC -> busy, done and result go 0 immediately; no done pulse afterwards; start plus flush in the same IDLE cycle -> not accepted.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential radix-2 RV32M/RV64M-style multiply/divide unit.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC/FIX.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [XLEN-1:0] a_r, b_r, d_r;
  logic [2*XLEN:0] acc;
  logic [CW-1:0] cnt;
  logic is_div, is_rem, a_sgn, b_sgn, sa, sb, dz, ovf, sp;
  logic [XLEN-1:0] a_abs, b_abs, sp_val, q_fix, r_fix, norm, result_nx;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic [2*XLEN:0] mul_step, div_step;
  always_comb begin
    is_div    = op[2];
    is_rem    = op[2] & op[1];
    a_sgn     = is_div ? ~op[0] : (op != 3'b011);
    b_sgn     = is_div ? ~op[0] : ~op[1];
    sa        = a_sgn & a_r[XLEN-1];
    sb        = b_sgn & b_r[XLEN-1];
    a_abs     = sa ? -a_r : a_r;
    b_abs     = sb ? -b_r : b_r;
    dz        = is_div & (b_r == '0);
    ovf       = is_div & ~op[0] & (a_r == {1'b1, {(XLEN-1){1'b0}}}) & (&b_r);
    sp        = dz | ovf;
    sp_val    = is_rem ? (dz ? a_r : '0) : (dz ? '1 : a_r);
    mul_sum   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, d_r} : '0);
    mul_step  = {mul_sum, acc[XLEN-1:0]} >> 1;
    div_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_sh - {1'b0, d_r};
    div_step  = div_diff[XLEN] ? {div_sh, acc[XLEN-2:0], 1'b0} : {div_diff, acc[XLEN-2:0], 1'b1};
    prod_fix  = (sa ^ sb) ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    q_fix     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_fix     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    norm      = is_div ? (is_rem ? r_fix : q_fix)
                       : (op == 3'b000 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    result_nx = sp ? sp_val : norm;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush && state != IDLE) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = (start && !flush) ? PREP : IDLE;
        PREP:    state_nx = (EARLY && sp) ? DONE : CALC;
        CALC:    state_nx = (cnt == CW'(1)) ? FIX : CALC;
        FIX:     state_nx = DONE;
        default: state_nx = IDLE;
      endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      op     <= '0;
      a_r    <= '0;
      b_r    <= '0;
      d_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && start && !flush) begin
        op  <= m_funct3;
        a_r <= operand_a;
        b_r <= operand_b;
      end
      if (state == PREP) begin
        acc <= {{(XLEN+1){1'b0}}, is_div ? a_abs : b_abs};
        d_r <= is_div ? b_abs : a_abs;
        cnt <= CW'(XLEN);
      end
      if (state == CALC) begin
        acc <= is_div ? div_step : mul_step;
        cnt <= cnt - CW'(1);
      end
      if (state != DONE && state_nx == DONE) result <= result_nx;
    end
endmodule
